// File: rtl/ef_wdt_pkg.sv
// Shared definitions for the windowed watchdog: FSM state encoding and width.
// No logic, no latency.
// No flow control; pure type/constant package.
package ef_wdt_pkg;

  // Width of the exported state field.
  localparam int STATE_W = 2;

  // Watchdog FSM states; encodings are visible on the state output.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    TRIP = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/ef_wdt_prescaler.sv
// Prescaler: free-running 0..div counter producing a one-cycle tick at div.
// Tick is combinational from the registered count (same-cycle as count==div).
// No backpressure; clr forces the count to 0 and has priority over en.
module ef_wdt_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // A tick fires in the cycle the count equals div; div is read live, so a
  // new divisor is honoured at the next compare.
  assign tick = en && (cnt_q == div);

  // Next count: clear, wrap after a tick, or advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ef_wdt_window.sv
// Windowed watchdog: prescaled down-counter, warn on first expiry, trip on second or early kick.
// All outputs registered; one clk from input change to output response.
// No backpressure; kick is a level sampled every cycle and wins over a coincident tick.
module ef_wdt_window
  import ef_wdt_pkg::*;
#(
  parameter int W  = 32,
  parameter int PW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [W-1:0]       load,
  input  logic [W-1:0]       window,
  input  logic [PW-1:0]      pre_div,
  input  logic               kick,
  output logic [W-1:0]       count,
  output logic               warn,
  output logic               to,
  output logic               early,
  output logic [STATE_W-1:0] state
);

  wdt_state_e state_q;
  logic [W-1:0] count_q;
  logic         warn_q;
  logic         to_q;
  logic         early_q;

  logic in_service;
  logic kick_legal;
  logic presc_clr;
  logic presc_en;
  logic tick;

  // Service decode: only RUN/WARN count down and react to kicks; the window
  // compare uses the live threshold so a new window applies immediately.
  always_comb begin
    in_service = en && ((state_q == RUN) || (state_q == WARN));
    kick_legal = in_service && kick && (count_q <= window);
    presc_en   = in_service;
    presc_clr  = !en || (state_q == IDLE) || kick_legal;
  end

  ef_wdt_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .div  (pre_div),
    .tick (tick)
  );

  // Watchdog FSM and down-counter; rst beats en, en=0 beats everything else,
  // and within RUN/WARN a kick discards any same-cycle tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      warn_q  <= 1'b0;
      to_q    <= 1'b0;
      early_q <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      count_q <= load;
      warn_q  <= 1'b0;
      to_q    <= 1'b0;
      early_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RUN;
          count_q <= load;
        end
        RUN, WARN: begin
          if (kick) begin
            if (count_q <= window) begin
              state_q <= RUN;
              count_q <= load;
              warn_q  <= 1'b0;
            end else begin
              // Kick before the window opened: trip with the count frozen.
              state_q <= TRIP;
              early_q <= 1'b1;
              to_q    <= 1'b1;
            end
          end else if (tick) begin
            if (count_q != '0) begin
              count_q <= count_q - W'(1);
            end else if (state_q == RUN) begin
              // First expiry: flag it and give software another full period.
              state_q <= WARN;
              warn_q  <= 1'b1;
              count_q <= load;
            end else begin
              // Second expiry: count stays at zero.
              state_q <= TRIP;
              to_q    <= 1'b1;
            end
          end
        end
        TRIP: begin
          // Terminal until en drops or rst; kicks have no effect here.
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign warn  = warn_q;
  assign to    = to_q;
  assign early = early_q;
  assign state = state_q;

endmodule
